// File: rtl/f5_sweep_ctrl.sv
// Exhaustive two-implementation gate sweeper: steps every input vector, settles, samples, compares.
// Optional macro SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatching minterm.
module f5_sweep_ctrl #(
   parameter int N      = 2,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [N-1:0]          vec,
   input  logic                  ya,
   input  logic                  yb,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N:0]            err_cnt,
   output logic [N-1:0]          first_err,
   output logic [(1<<N)-1:0]     table_a
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

   logic [1:0]          state_q, state_d;
   logic [N-1:0]        vec_q, vec_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [N:0]          err_q, err_d;
   logic [N-1:0]        ferr_q, ferr_d;
   logic [(1<<N)-1:0]   tbl_q, tbl_d;
   logic                pass_q, pass_d;
   logic                mismatch;
   logic                stop;

   assign mismatch = ya ^ yb;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      tbl_d   = tbl_q;
      pass_d  = pass_q;
      stop    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               vec_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               ferr_d  = '0;
               tbl_d   = '0;
               pass_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            tbl_d[vec_q] = ya;
            if (mismatch) begin
               err_d = err_q + (N+1)'(1);
               if (err_q == '0) begin
                  ferr_d = vec_q;
               end
            end
`ifdef SWEEP_STOP_ON_ERR_EN
            stop = (&vec_q) | mismatch;
`else
            stop = &vec_q;
`endif
            if (stop) begin
               // pass is committed here so it is already valid during the done pulse
               state_d = S_DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_SETTLE;
               vec_d   = vec_q + N'(1);
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ferr_q  <= '0;
         tbl_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         tbl_q   <= tbl_d;
         pass_q  <= pass_d;
      end
   end

   assign vec       = vec_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign err_cnt   = err_q;
   assign first_err = ferr_q;
   assign table_a   = tbl_q;

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// Directed scoreboard bench for f5_sweep_ctrl: an N=2/SETTLE=1 instance and an N=3/SETTLE=3 instance.
// Expectations follow SWEEP_STOP_ON_ERR_EN when the bench is built with it.
module tb_f5_sweep_ctrl;

   typedef struct {
      int cyc;
      int pass;
      int err;
      int ferr;
      int tbl;
      int vlast;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start1, start2, fault;
   int   sel;

   logic [1:0] vec1;  logic ya1, yb1, busy1, done1, pass1;
   logic [2:0] err1;  logic [1:0] ferr1; logic [3:0] tbl1;
   logic [2:0] vec2;  logic ya2, yb2, busy2, done2, pass2;
   logic [3:0] err2;  logic [2:0] ferr2; logic [7:0] tbl2;

   assign ya1 = ~vec1[1] & vec1[0];
   assign yb1 = fault ? (vec1[1] & vec1[0]) : ya1;
   assign ya2 = ~vec2[2] & vec2[0];
   assign yb2 = ya2;

   f5_sweep_ctrl #(.N(2), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .vec(vec1), .ya(ya1), .yb(yb1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err(ferr1), .table_a(tbl1));

   f5_sweep_ctrl #(.N(3), .SETTLE(3)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .vec(vec2), .ya(ya2), .yb(yb2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err(ferr2), .table_a(tbl2));

   logic [31:0] o_vec, o_busy, o_done, o_pass, o_err, o_ferr, o_tbl;
   assign o_vec  = (sel != 0) ? 32'(vec2)  : 32'(vec1);
   assign o_busy = (sel != 0) ? 32'(busy2) : 32'(busy1);
   assign o_done = (sel != 0) ? 32'(done2) : 32'(done1);
   assign o_pass = (sel != 0) ? 32'(pass2) : 32'(pass1);
   assign o_err  = (sel != 0) ? 32'(err2)  : 32'(err1);
   assign o_ferr = (sel != 0) ? 32'(ferr2) : 32'(ferr1);
   assign o_tbl  = (sel != 0) ? 32'(tbl2)  : 32'(tbl1);

   int   ntests = 0;
   int   nfail  = 0;
   exp_t sbq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input int s, input logic v);
      if (s != 0) start2 = v;
      else        start1 = v;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vec"},  o_vec,  0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_pass"}, o_pass, 0);
      chk({tag, "_err"},  o_err,  0);
      chk({tag, "_ferr"}, o_ferr, 0);
      chk({tag, "_tbl"},  o_tbl,  0);
   endtask

   // Called with time just after a posedge while the DUT sits in IDLE.
   task automatic sweep(input int s, input exp_t ex, input int xa, input int xb,
                        input int rst_at, input int setl);
      exp_t e;
      int   k;
      sel = s;
      sbq.push_back(ex);
      drive_start(s, 1'b1);
      @(posedge clk); #1;
      drive_start(s, 1'b0);
      chk("busy_rise", o_busy, 1);
      chk("clr_err",   o_err,  0);
      chk("clr_tbl",   o_tbl,  0);
      chk("clr_pass",  o_pass, 0);
      k = 1;
      while (k <= 200) begin
         drive_start(s, (k == xa || k == xb) ? 1'b1 : 1'b0);
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_zero("abort");
            void'(sbq.pop_front());
            @(posedge clk); @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
         if (o_done == 1) break;
         chk("vec_step", o_vec, 32'((k - 1) / (setl + 1)));
         @(posedge clk); #1;
         k++;
      end
      drive_start(s, 1'b0);
      chk("done_seen", o_done, 1);
      e = sbq.pop_front();
      chk("done_cycle", 32'(k),  32'(e.cyc));
      chk("pass",       o_pass,  32'(e.pass));
      chk("err_cnt",    o_err,   32'(e.err));
      chk("first_err",  o_ferr,  32'(e.ferr));
      chk("table_a",    o_tbl,   32'(e.tbl));
      chk("vec_last",   o_vec,   32'(e.vlast));
      @(posedge clk); #1;
      chk("done_once",  o_done,  0);
      chk("busy_fall",  o_busy,  0);
      chk("hold_pass",  o_pass,  32'(e.pass));
      chk("hold_err",   o_err,   32'(e.err));
      chk("hold_tbl",   o_tbl,   32'(e.tbl));
   endtask

   initial begin
      exp_t good, bad, good3;
      rst_n  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      fault  = 1'b0;
      sel    = 0;
      good   = '{9, 1, 0, 0, 4'b0010, 3};
`ifdef SWEEP_STOP_ON_ERR_EN
      bad    = '{5, 0, 1, 1, 4'b0010, 1};
`else
      bad    = '{9, 0, 2, 1, 4'b0010, 3};
`endif
      good3  = '{33, 1, 0, 0, 8'b00001010, 7};

      #12;
      chk_zero("rst1");
      sel = 1;
      #1;
      chk_zero("rst2");
      sel = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      sweep(0, good, 0, 0, 0, 1);
      // back-to-back: start on the cycle after done
      sweep(0, good, 0, 0, 0, 1);
      fault = 1'b1;
      sweep(0, bad, 0, 0, 0, 1);
      fault = 1'b0;
      sweep(0, good, 3, 8, 0, 1);
      sweep(0, good, 0, 0, 4, 1);
      sweep(0, good, 0, 0, 0, 1);
      sweep(1, good3, 0, 0, 0, 3);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
